// File: rtl/sipo_rx_reg.sv
// -----------------------------------------------------------------------------
// sipo_rx_reg
//   Serial-in / parallel-out receive register. Collects an MSB-first,
//   shift-left serial stream (one bit per cycle with sen_i high) into a
//   Width-bit word. Completed words go to an output buffer with a
//   valid/ready handshake, which lets the next frame be received while the
//   consumer still holds the previous one.
//
//   Optional feature macro: SIPO_PARITY_CHECK_EN
//     defined   - each frame is Width data bits plus one even-parity bit.
//                 perr_o reports the parity result for the word on q_o.
//     undefined - frames are Width bits long and perr_o is tied to 0.
//
// Ports
//   clk_i    in   1      system clock, rising edge
//   rst_i    in   1      asynchronous reset, active high
//   sd_i     in   1      serial data, MSB first, sampled when sen_i=1
//   sen_i    in   1      bit strobe
//   clr_i    in   1      synchronous clear/abort, overrides sen_i
//   q_o      out  Width  received word (output buffer)
//   valid_o  out  1      q_o holds an unconsumed word
//   ready_i  in   1      consumer takes q_o when valid_o & ready_i
//   busy_o   out  1      a frame is partially received
//   ovf_o    out  1      sticky: a completed frame was dropped
//   perr_o   out  1      parity error flag for the word on q_o
// -----------------------------------------------------------------------------
module sipo_rx_reg #(
  parameter int Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sd_i,
  input  logic             sen_i,
  input  logic             clr_i,
  output logic [Width-1:0] q_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             ovf_o,
  output logic             perr_o
);

  // state  | meaning
  // IDLE   | no frame in progress, bit counter at 0
  // RECV   | data bits of a frame are being shifted in
  // PARITY | all data bits held in sr, waiting for the parity bit
`ifdef SIPO_PARITY_CHECK_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    PARITY = 2'd2
  } state_t;
  // The full data word must survive in sr until the parity bit arrives.
  localparam int SrW = Width;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1
  } state_t;
  // Without a parity stage the completed word is formed from the low
  // Width-1 stored bits plus the incoming bit, so the top bit is never needed.
  localparam int SrW = Width - 1;
`endif

  localparam int            CntW     = $clog2(Width + 1);
  localparam logic [CntW-1:0] LastData = CntW'(Width - 1);

  state_t            state, state_nxt;
  logic [SrW-1:0]    sr, sr_nxt;
  logic [CntW-1:0]   cnt, cnt_nxt;
  logic [SrW:0]      sr_ext;
  logic              done;
  logic [Width-1:0]  word;
`ifdef SIPO_PARITY_CHECK_EN
  logic              perr_new;
  logic              perr_q;
`endif

  // Existing contents with the incoming bit appended on the right.
  assign sr_ext = {sr, sd_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    done      = 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
    word      = sr;
    perr_new  = 1'b0;
`else
    word      = sr_ext;
`endif
    if (clr_i) begin
      state_nxt = IDLE;
      sr_nxt    = '0;
      cnt_nxt   = '0;
    end else if (sen_i) begin
      sr_nxt = sr_ext[SrW-1:0];
      case (state)
        IDLE: begin
          cnt_nxt   = CntW'(1);
          state_nxt = RECV;
        end
        RECV: begin
          if (cnt == LastData) begin
`ifdef SIPO_PARITY_CHECK_EN
            cnt_nxt   = cnt + CntW'(1);
            state_nxt = PARITY;
`else
            cnt_nxt   = '0;
            done      = 1'b1;
            state_nxt = IDLE;
`endif
          end else begin
            cnt_nxt = cnt + CntW'(1);
          end
        end
`ifdef SIPO_PARITY_CHECK_EN
        PARITY: begin
          // Even parity over data and parity bit: a set result is an error.
          cnt_nxt   = '0;
          done      = 1'b1;
          perr_new  = ^sr_ext;
          state_nxt = IDLE;
        end
`endif
        default: begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign busy_o = (state != IDLE);

  // Output buffer. A completing frame is accepted when the buffer is empty
  // or is being emptied on this same edge; otherwise the new frame is
  // dropped and the overflow flag latches.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_o     <= '0;
      valid_o <= 1'b0;
      ovf_o   <= 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
      perr_q  <= 1'b0;
`endif
    end else if (clr_i) begin
      valid_o <= 1'b0;
      ovf_o   <= 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
      perr_q  <= 1'b0;
`endif
    end else if (done) begin
      if (!valid_o || ready_i) begin
        q_o     <= word;
        valid_o <= 1'b1;
`ifdef SIPO_PARITY_CHECK_EN
        perr_q  <= perr_new;
`endif
      end else begin
        ovf_o <= 1'b1;
      end
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

`ifdef SIPO_PARITY_CHECK_EN
  assign perr_o = perr_q;
`else
  assign perr_o = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx_reg.sv
module tb_sipo_rx_reg;

  logic       clk;
  logic       rst;
  logic       sd;
  logic       sen;
  logic       clr;
  logic [7:0] q;
  logic       valid;
  logic       ready;
  logic       busy;
  logic       ovf;
  logic       perr;

  int checks = 0;
  int errors = 0;

  sipo_rx_reg #(.Width(8)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .sd_i    (sd),
    .sen_i   (sen),
    .clr_i   (clr),
    .q_o     (q),
    .valid_o (valid),
    .ready_i (ready),
    .busy_o  (busy),
    .ovf_o   (ovf),
    .perr_o  (perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sends one frame (data bits MSB first, plus the parity bit when enabled).
  // gap inserts one idle cycle between strobes. rdy_last raises ready only
  // for the completing strobe. Returns at the negedge after the final edge.
  task automatic send_word(input logic [7:0] w, input bit gap,
                           input bit bad_par, input bit rdy_last);
    for (int i = 7; i >= 0; i--) begin
      if (gap && i != 7) begin
        @(negedge clk); sen = 1'b0;
      end
      @(negedge clk); sd = w[i]; sen = 1'b1;
`ifndef SIPO_PARITY_CHECK_EN
      if (i == 0 && rdy_last) ready = 1'b1;
`endif
    end
`ifdef SIPO_PARITY_CHECK_EN
    if (gap) begin
      @(negedge clk); sen = 1'b0;
    end
    @(negedge clk); sd = (^w) ^ bad_par; sen = 1'b1;
    if (rdy_last) ready = 1'b1;
`else
    if (bad_par) sd = sd;
`endif
    @(negedge clk); sen = 1'b0;
    if (rdy_last) ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; sd = 1'b0; sen = 1'b0; clr = 1'b0; ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got %h exp 00", q); end
    checks++; if ({valid, busy, ovf, perr} !== 4'b0000) begin errors++;
      $display("FAIL reset_flags got %b exp 0000", {valid, busy, ovf, perr}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [7:0] w;
    w = 8'hA5;
    ready = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk); sd = w[i]; sen = 1'b1;
      @(negedge clk); sen = 1'b0;
      if (i == 7) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_first got %b exp 1", busy); end
      end
      if (i == 1) begin
        checks++; if ({busy, valid} !== 2'b10) begin errors++;
          $display("FAIL basic_busy_mid got busy,valid=%b exp 10", {busy, valid}); end
      end
    end
`ifdef SIPO_PARITY_CHECK_EN
    @(negedge clk); sd = 1'b0; sen = 1'b1;
    @(negedge clk); sen = 1'b0;
`endif
    checks++; if ({valid, busy} !== 2'b10) begin errors++;
      $display("FAIL basic_done got valid,busy=%b exp 10", {valid, busy}); end
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL basic_q got %h exp a5", q); end
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_handshake got valid=%b exp 0", valid); end
    ready = 1'b0;
  endtask

  task automatic test_overflow;
    ready = 1'b0;
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    checks++; if ({valid, ovf, q} !== {2'b10, 8'hA5}) begin errors++;
      $display("FAIL ovf_first got valid=%b ovf=%b q=%h exp 1 0 a5", valid, ovf, q); end
    send_word(8'h3C, 1'b1, 1'b0, 1'b0);
    checks++; if ({valid, ovf, q} !== {2'b11, 8'hA5}) begin errors++;
      $display("FAIL ovf_drop got valid=%b ovf=%b q=%h exp 1 1 a5", valid, ovf, q); end
    ready = 1'b1;
    @(negedge clk); ready = 1'b0;
    checks++; if ({valid, ovf} !== 2'b01) begin errors++;
      $display("FAIL ovf_sticky got valid=%b ovf=%b exp 0 1", valid, ovf); end
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    checks++; if ({ovf, q} !== {1'b0, 8'hA5}) begin errors++;
      $display("FAIL ovf_clr got ovf=%b q=%h exp 0 a5", ovf, q); end
  endtask

  task automatic test_simultaneous;
    ready = 1'b0;
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0, 1'b0, 1'b1);
    checks++; if ({valid, ovf, q} !== {2'b10, 8'h3C}) begin errors++;
      $display("FAIL simul got valid=%b ovf=%b q=%h exp 1 0 3c", valid, ovf, q); end
    ready = 1'b1;
    @(negedge clk); ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL simul_drain got valid=%b exp 0", valid); end
  endtask

  task automatic test_clear;
    logic [3:0] part;
    part = 4'b1101;
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk); sd = part[i]; sen = 1'b1;
    end
    @(negedge clk); sen = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_partial_busy got %b exp 1", busy); end
    @(negedge clk); clr = 1'b1; sen = 1'b1; sd = 1'b1;
    @(negedge clk); clr = 1'b0; sen = 1'b0;
    checks++; if ({busy, valid, q} !== {2'b00, 8'h3C}) begin errors++;
      $display("FAIL clr_state got busy=%b valid=%b q=%h exp 0 0 3c", busy, valid, q); end
    send_word(8'hFF, 1'b0, 1'b0, 1'b0);
    checks++; if ({valid, busy, q} !== {2'b10, 8'hFF}) begin errors++;
      $display("FAIL clr_refill got valid=%b busy=%b q=%h exp 1 0 ff", valid, busy, q); end
    ready = 1'b1;
    @(negedge clk); ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    ready = 1'b1;
    send_word(8'h5A, 1'b0, 1'b0, 1'b0);
    checks++; if ({valid, q} !== {1'b1, 8'h5A}) begin errors++;
      $display("FAIL b2b_first got valid=%b q=%h exp 1 5a", valid, q); end
    send_word(8'hC3, 1'b0, 1'b0, 1'b0);
    checks++; if ({valid, ovf, q} !== {2'b10, 8'hC3}) begin errors++;
      $display("FAIL b2b_second got valid=%b ovf=%b q=%h exp 1 0 c3", valid, ovf, q); end
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got valid=%b exp 0", valid); end
    ready = 1'b0;
  endtask

  task automatic test_mid_reset;
    ready = 1'b0;
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); sd = 1'b1; sen = 1'b1;
    end
    @(negedge clk); sen = 1'b0;
    checks++; if ({busy, ovf, valid} !== 3'b111) begin errors++;
      $display("FAIL mid_pre got busy,ovf,valid=%b exp 111", {busy, ovf, valid}); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({q, valid, busy, ovf, perr} !== 12'h000) begin errors++;
      $display("FAIL mid_reset got q=%h valid=%b busy=%b ovf=%b perr=%b exp 00 0 0 0 0",
               q, valid, busy, ovf, perr); end
    @(negedge clk); rst = 1'b0;
    send_word(8'h81, 1'b1, 1'b0, 1'b0);
    checks++; if ({valid, busy, q} !== {2'b10, 8'h81}) begin errors++;
      $display("FAIL mid_after got valid=%b busy=%b q=%h exp 1 0 81", valid, busy, q); end
    ready = 1'b1;
    @(negedge clk); ready = 1'b0;
  endtask

`ifdef SIPO_PARITY_CHECK_EN
  task automatic test_parity;
    ready = 1'b1;
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    checks++; if ({valid, perr, q} !== {2'b10, 8'hA5}) begin errors++;
      $display("FAIL par_good got valid=%b perr=%b q=%h exp 1 0 a5", valid, perr, q); end
    send_word(8'hA5, 1'b1, 1'b1, 1'b0);
    checks++; if ({valid, perr, q} !== {2'b11, 8'hA5}) begin errors++;
      $display("FAIL par_bad got valid=%b perr=%b q=%h exp 1 1 a5", valid, perr, q); end
    ready = 1'b0;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL par_clr got perr=%b exp 0", perr); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_simultaneous();
    test_clear();
    test_back_to_back();
    test_mid_reset();
`ifdef SIPO_PARITY_CHECK_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
